redmule_job_dispatcher: RTL and testbench

Hardware initiator for the RedMulE peripheral control port, so jobs can be offloaded without a core driving the registers.
- Accepts a job descriptor of N_JOB_REGS words and acquires a context by reading ACQUIRE, retrying while busy.
- Writes the job registers in order, writes TRIGGER, then returns the job ID on a completion stream when the accelerator's done event fires.
- Sits between a job-queue producer (DMA or command FIFO) and the accelerator's hwpe_ctrl slave port.

---
 rtl/redmule_job_dispatcher_pkg.sv | 25 ++
 rtl/redmule_job_dispatcher_if.sv | 20 ++
 rtl/redmule_job_dispatcher_id_fifo.sv | 44 ++++
 rtl/redmule_job_dispatcher.sv | 159 +++++++++++++++
 tb/tb_redmule_job_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/redmule_job_dispatcher_pkg.sv
// redmule_job_dispatcher_pkg: shared constants, state encoding and helpers for the RedMulE job dispatcher.
// Contents: default register offsets, ACQUIRE busy-bit index, dispatch_state_e,
// legacy 3-bit state constants and the watchdog state-membership helper.
package redmule_job_dispatcher_pkg;

    localparam logic [31:0] DEF_JOB_OFFS  = 32'h40;
    localparam logic [31:0] DEF_ACQ_OFFS  = 32'h04;
    localparam logic [31:0] DEF_TRIG_OFFS = 32'h00;
    localparam int          BUSY_BIT      = 31;

    typedef enum logic [2:0] {IDLE, ACQ_REQ, ACQ_RESP, ACQ_GAP, WR_JOB, TRIG} dispatch_state_e;

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_ACQ_REQ  = ACQ_REQ;
    localparam logic [2:0] S_ACQ_RESP = ACQ_RESP;
    localparam logic [2:0] S_ACQ_GAP  = ACQ_GAP;
    localparam logic [2:0] S_WR_JOB   = WR_JOB;
    localparam logic [2:0] S_TRIG     = TRIG;

    // States in which the dispatcher is waiting on the accelerator port.
    function automatic logic is_watched(input logic [2:0] s);
        return s == S_ACQ_REQ || s == S_ACQ_RESP || s == S_WR_JOB || s == S_TRIG;
    endfunction

endpackage

// File: rtl/redmule_job_dispatcher_if.sv
// redmule_job_dispatcher_if: hwpe periph control-port bundle between the dispatcher and the accelerator.
// Signals: req/gnt handshake, add (byte address), wen (1=read), be, data (write data), id,
// r_valid/r_data/r_id read response. master = dispatcher side, slave = accelerator side.
interface redmule_job_dispatcher_if #(
    parameter int unsigned ID_WIDTH = 8
);
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic                r_valid;
    logic [31:0]         r_data;
    logic [ID_WIDTH-1:0] r_id;

    modport master (output req, add, wen, be, data, id, input gnt, r_valid, r_data, r_id);
    modport slave  (input req, add, wen, be, data, id, output gnt, r_valid, r_data, r_id);
endinterface

// File: rtl/redmule_job_dispatcher_id_fifo.sv
// redmule_id_fifo: in-order FIFO of job IDs for jobs triggered but not yet completed.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i, pop_i/data_o (head), full_o, empty_o.
// A push while full is accepted only together with a pop.
module redmule_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr, rd;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full_o  = cnt == CW'(DEPTH);
    assign empty_o = cnt == '0;
    assign data_o  = mem[rd];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr  <= '0;
            rd  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr] <= data_i;
            wr  <= do_push ? (wr == PW'(DEPTH - 1) ? '0 : wr + PW'(1)) : wr;
            rd  <= do_pop ? (rd == PW'(DEPTH - 1) ? '0 : rd + PW'(1)) : rd;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/redmule_job_dispatcher.sv
// redmule_job_dispatcher: hardware initiator that offloads job descriptors to a RedMulE control port.
// Ports: clk_i, rst_i (sync, active-high); job_valid_i/job_ready_o/job_regs_i descriptor stream;
// done_valid_o/done_ready_i/done_id_o completion stream; busy_o; periph (master modport of
// redmule_job_dispatcher_if); evt_i accelerator events (bit0 = job done); err_o sticky error.
// Optional: define REDMULE_DISPATCH_TIMEOUT_EN to add a 16-bit watchdog that aborts stuck jobs.
module redmule_job_dispatcher
    import redmule_job_dispatcher_pkg::*;
#(
    parameter int unsigned         N_JOB_REGS = 12,
    parameter int unsigned         ID_WIDTH   = 8,
    parameter int unsigned         N_CONTEXT  = 2,
    parameter logic [31:0]         BASE_ADDR  = 32'h0,
    parameter logic [31:0]         JOB_OFFS   = DEF_JOB_OFFS,
    parameter logic [31:0]         ACQ_OFFS   = DEF_ACQ_OFFS,
    parameter logic [31:0]         TRIG_OFFS  = DEF_TRIG_OFFS,
    parameter int unsigned         RETRY_GAP  = 4,
    parameter logic [ID_WIDTH-1:0] MY_ID      = 8'h5A
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [32*N_JOB_REGS-1:0] job_regs_i,
    output logic                     done_valid_o,
    input  logic                     done_ready_i,
    output logic [7:0]               done_id_o,
    output logic                     busy_o,
    redmule_job_dispatcher_if.master periph,
    input  logic [1:0]               evt_i,
    output logic                     err_o
);
    localparam int IW = $clog2(N_JOB_REGS);
    localparam int CW = $clog2(N_CONTEXT + 1);
    localparam int GW = $clog2(RETRY_GAP + 1);

    logic [2:0]    state, state_n;
    logic [IW-1:0] idx;
    logic [7:0]    job_id;
    logic          cooldown;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   regs [N_JOB_REGS];
    logic [CW-1:0] inflight, pend;
    logic          done_valid_q, err_q, abort;
    logic [7:0]    done_id_q, fifo_head;
    logic          req, grant, accept, rsp, last, push, pop, evt_ok, out_free, ovf;
    logic          fifo_full, fifo_empty, unused_bits;

    // cooldown masks req for the cycle after each grant, so every transaction is 2 cycles minimum.
    assign req         = is_watched(state) && state != S_ACQ_RESP && !cooldown && !abort;
    assign grant       = req && periph.gnt;
    assign job_ready_o = !rst_i && state == S_IDLE && inflight < CW'(N_CONTEXT);
    assign accept      = job_valid_i && job_ready_o;
    assign rsp         = state == S_ACQ_RESP && periph.r_valid && periph.r_id == MY_ID;
    assign last        = idx == IW'(N_JOB_REGS - 1);
    assign push        = state == S_TRIG && grant;
    assign busy_o      = state != S_IDLE || inflight != '0;
    assign unused_bits = ^{evt_i[1], periph.r_data[30:8], fifo_full};

    assign periph.req  = req;
    assign periph.wen  = state == S_ACQ_REQ;
    assign periph.be   = 4'hF;
    assign periph.id   = MY_ID;
    assign periph.data = state == S_WR_JOB ? regs[idx] : '0;
    assign periph.add  = state == S_ACQ_REQ ? BASE_ADDR + ACQ_OFFS :
                         state == S_WR_JOB  ? BASE_ADDR + JOB_OFFS + 32'({idx, 2'b00}) :
                         state == S_TRIG    ? BASE_ADDR + TRIG_OFFS : '0;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:     state_n = accept ? S_ACQ_REQ : S_IDLE;
            S_ACQ_REQ:  state_n = grant ? S_ACQ_RESP : S_ACQ_REQ;
            S_ACQ_RESP: state_n = !rsp ? S_ACQ_RESP : periph.r_data[BUSY_BIT] ? S_ACQ_GAP : S_WR_JOB;
            S_ACQ_GAP:  state_n = gap_cnt == GW'(RETRY_GAP - 1) ? S_ACQ_REQ : S_ACQ_GAP;
            S_WR_JOB:   state_n = grant && last ? S_TRIG : S_WR_JOB;
            S_TRIG:     state_n = grant ? S_IDLE : S_TRIG;
            default:    state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            idx      <= '0;
            job_id   <= '0;
            cooldown <= 1'b0;
            gap_cnt  <= '0;
            for (int i = 0; i < N_JOB_REGS; i++) regs[i] <= '0;
        end else begin
            state    <= state_n;
            cooldown <= grant;
            gap_cnt  <= state == S_ACQ_GAP ? gap_cnt + GW'(1) : '0;
            if (accept)
                for (int i = 0; i < N_JOB_REGS; i++) regs[i] <= job_regs_i[32*i +: 32];
            if (rsp && !periph.r_data[BUSY_BIT]) begin
                job_id <= periph.r_data[7:0];
                idx    <= '0;
            end else if (state == S_WR_JOB && grant && !last) begin
                idx <= idx + IW'(1);
            end
        end
    end

`ifdef REDMULE_DISPATCH_TIMEOUT_EN
    logic [15:0] wd;

    assign abort = is_watched(state) && wd == '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) wd <= '1;
        else if (state_n != state && is_watched(state_n)) wd <= '1;
        else if (is_watched(state)) wd <= wd - 16'd1;
    end
`else
    assign abort = 1'b0;
`endif

    // An event is valid only if some triggered job has not yet been matched by an earlier event.
    assign evt_ok   = evt_i[0] && inflight > pend;
    assign out_free = !done_valid_q || done_ready_i;
    assign pop      = (evt_ok || pend != '0) && out_free && !fifo_empty;
    assign ovf      = evt_ok && !pop && pend == '1;

    redmule_id_fifo #(
        .DEPTH (N_CONTEXT),
        .WIDTH (8)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (job_id),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight     <= '0;
            pend         <= '0;
            done_valid_q <= 1'b0;
            done_id_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            inflight     <= push && !pop && inflight == CW'(N_CONTEXT) ? inflight
                                                                      : inflight + CW'(push) - CW'(pop);
            pend         <= ovf ? pend : pend + CW'(evt_ok) - CW'(pop);
            done_valid_q <= pop || (done_valid_q && !done_ready_i);
            done_id_q    <= pop ? fifo_head : done_id_q;
            err_q        <= err_q || (evt_i[0] && !evt_ok) || ovf || abort;
        end
    end

    assign done_valid_o = done_valid_q;
    assign done_id_o    = done_id_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_redmule_job_dispatcher.sv
// tb_redmule_job_dispatcher: self-checking bench for redmule_job_dispatcher with an accelerator port model.
module tb_redmule_job_dispatcher;
    localparam int         NREG  = 12;
    localparam logic [7:0] MY_ID = 8'h5A;

    logic                clk = 1'b0, rst = 1'b1;
    logic                job_valid = 1'b0, done_ready = 1'b0;
    logic [32*NREG-1:0]  job_regs = '0;
    logic [1:0]          evt = 2'b00;
    logic                job_ready, done_valid, busy, err;
    logic [7:0]          done_id;
    int                  vectors = 0, miscompares = 0;
    logic [7:0]          fifo_q[$], done_q[$];
    logic                exp_err = 1'b0;

    redmule_job_dispatcher_if #(.ID_WIDTH(8)) pif ();

    redmule_job_dispatcher dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .job_valid_i  (job_valid),
        .job_ready_o  (job_ready),
        .job_regs_i   (job_regs),
        .done_valid_o (done_valid),
        .done_ready_i (done_ready),
        .done_id_o    (done_id),
        .busy_o       (busy),
        .periph       (pif),
        .evt_i        (evt),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (pif.req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, " req timeout"}, 32'(pif.req), 1);
    endtask

    task automatic grant(input string tag, input int dmin, input int dmax);
        logic [31:0] a, d;
        int dly;
        a = pif.add;
        d = pif.data;
        dly = $urandom_range(dmax, dmin);
        repeat (dly) begin
            tick();
            chk({tag, " hold req"}, 32'(pif.req), 1);
            chk({tag, " hold add"}, pif.add, a);
            chk({tag, " hold data"}, pif.data, d);
        end
        pif.gnt = 1'b1;
        tick();
        pif.gnt = 1'b0;
        chk({tag, " req drop"}, 32'(pif.req), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        job_valid = 1'b0;
        done_ready = 1'b0;
        evt = 2'b00;
        pif.gnt = 1'b0;
        pif.r_valid = 1'b0;
        pif.r_id = '0;
        pif.r_data = '0;
        tick();
        chk("rst req", 32'(pif.req), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done_valid", 32'(done_valid), 0);
        chk("rst err", 32'(err), 0);
        chk("rst job_ready", 32'(job_ready), 0);
        chk("rst id", 32'(pif.id), 32'(MY_ID));
        chk("rst be", 32'(pif.be), 32'hF);
        chk("rst add", pif.add, 0);
        chk("rst wen", 32'(pif.wen), 0);
        chk("rst done_id", 32'(done_id), 0);
        rst = 1'b0;
        #1;
        chk("post-rst job_ready", 32'(job_ready), 1);
        fifo_q.delete();
        done_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic pulse_evt();
        evt = 2'b01;
        tick();
        evt = 2'b00;
        if (fifo_q.size() == 0) exp_err = 1'b1;
        else done_q.push_back(fifo_q.pop_front());
    endtask

    task automatic drain();
        int w;
        while (done_q.size() != 0) begin
            w = $urandom_range(3);
            repeat (w) begin
                chk("done held valid", 32'(done_valid), 1);
                chk("done held id", 32'(done_id), 32'(done_q[0]));
                tick();
            end
            chk("done valid", 32'(done_valid), 1);
            chk("done id", 32'(done_id), 32'(done_q[0]));
            done_ready = 1'b1;
            tick();
            done_ready = 1'b0;
            void'(done_q.pop_front());
        end
        chk("done empty", 32'(done_valid), 0);
    endtask

    task automatic run_job(input logic [7:0] jid, input int nbusy, input int dmin, input int dmax,
                           input bit evt_at_trig, input int stop_at, input bit bad_id);
        logic [31:0] desc [NREG];
        logic [31:0] rsp;
        int n;
        for (int i = 0; i < NREG; i++) begin
            desc[i] = $urandom;
            job_regs[32*i +: 32] = desc[i];
        end
        n = 0;
        while (job_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("job_ready", 32'(job_ready), 1);
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        chk("busy after accept", 32'(busy), 1);
        for (int a = 0; a <= nbusy; a++) begin
            wait_req("acq");
            chk("acq add", pif.add, 32'h04);
            chk("acq wen", 32'(pif.wen), 1);
            grant("acq", dmin, dmax);
            if (bad_id) begin
                pif.r_valid = 1'b1;
                pif.r_id = 8'hA5;
                pif.r_data = 32'h0;
                tick();
                pif.r_valid = 1'b0;
                chk("foreign id ignored", 32'(pif.req), 0);
            end
            rsp = a < nbusy ? (a == 0 ? 32'hFFFF_FFFF : 32'h8000_0000 | $urandom)
                            : {1'b0, 23'($urandom), jid};
            pif.r_valid = 1'b1;
            pif.r_id = MY_ID;
            pif.r_data = rsp;
            tick();
            pif.r_valid = 1'b0;
            pif.r_data = '0;
            if (a < nbusy) begin
                n = 0;
                while (pif.req !== 1'b1 && n < 50) begin
                    tick();
                    n++;
                end
                chk("retry gap", 32'(n >= 4), 1);
            end
        end
        for (int i = 0; i < NREG; i++) begin
            wait_req("wr");
            chk("wr add", pif.add, 32'h40 + 32'(4 * i));
            if (i == stop_at) return;
            chk("wr data", pif.data, desc[i]);
            chk("wr wen", 32'(pif.wen), 0);
            grant("wr", dmin, dmax);
        end
        wait_req("trig");
        chk("trig add", pif.add, 32'h0);
        chk("trig data", pif.data, 32'h0);
        chk("trig wen", 32'(pif.wen), 0);
        if (evt_at_trig) begin
            pif.gnt = 1'b1;
            evt = 2'b01;
            tick();
            pif.gnt = 1'b0;
            evt = 2'b00;
            fifo_q.push_back(jid);
            done_q.push_back(fifo_q.pop_front());
        end else begin
            grant("trig", dmin, dmax);
            fifo_q.push_back(jid);
        end
        chk("ready vs inflight", 32'(job_ready), 32'(fifo_q.size() < 2));
    endtask

    initial begin
        pif.gnt = 1'b0;
        pif.r_valid = 1'b0;
        pif.r_id = '0;
        pif.r_data = '0;
        do_reset();

        run_job(8'h03, 0, 0, 0, 1'b0, 99, 1'b0);
        pulse_evt();
        drain();
        chk("idle after job", 32'(busy), 0);

        run_job(8'h01, 2, 0, 0, 1'b0, 99, 1'b0);
        pulse_evt();
        drain();

        run_job(8'h00, 0, 0, 1, 1'b0, 99, 1'b0);
        run_job(8'h01, 0, 0, 1, 1'b0, 99, 1'b0);
        chk("ready at full", 32'(job_ready), 0);
        pulse_evt();
        pulse_evt();
        drain();

        run_job(8'($urandom), 0, 5, 5, 1'b0, 99, 1'b1);
        pulse_evt();
        drain();

        run_job(8'h11, 0, 0, 2, 1'b0, 99, 1'b0);
        run_job(8'h22, 1, 0, 2, 1'b1, 99, 1'b0);
        drain();
        pulse_evt();
        drain();
        chk("idle after overlap", 32'(busy), 0);

        pulse_evt();
        chk("err on empty evt", 32'(err), 32'(exp_err));
        chk("no done on empty evt", 32'(done_valid), 0);

        do_reset();
        run_job(8'h44, 0, 0, 1, 1'b0, 6, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid rst req", 32'(pif.req), 0);
        chk("mid rst busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        chk("mid rst ready", 32'(job_ready), 1);
        fifo_q.delete();
        done_q.delete();
        pif.r_valid = 1'b1;
        pif.r_id = MY_ID;
        pif.r_data = 32'h7;
        tick();
        pif.r_valid = 1'b0;
        chk("stale rsp req", 32'(pif.req), 0);
        chk("stale rsp busy", 32'(busy), 0);
        chk("stale rsp done", 32'(done_valid), 0);
        chk("stale rsp err", 32'(err), 0);

        for (int k = 0; k < 8; k++) begin
            run_job(8'($urandom), int'($urandom_range(2)), int'($urandom_range(1)),
                    int'($urandom_range(3)) + 1, 1'b0, 99, 1'($urandom_range(1)));
            if (k % 2 == 1) run_job(8'($urandom), 0, 0, 2, 1'b0, 99, 1'b0);
            while (fifo_q.size() != 0) pulse_evt();
            drain();
            chk("rand err", 32'(err), 32'(exp_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
